// File: rtl/dse_stream_endpoint.sv
// rtl/dse_stream_endpoint.sv - DSE reset/DEG event recorder with tagged record FIFO.
// Optional finish timestamp: define DSE_FINISH_TIMESTAMP_EN.
module dse_stream_endpoint #(
  parameter int          DEG_W            = 512,
  parameter int          PERF_W           = 256,
  parameter int          MAGIC_W          = 8,
  parameter int          LANES            = 6,
  parameter int          FIFO_DEPTH       = 8,
  parameter int          DEG_RECORD_THRES = 200,
  parameter logic [35:0] WORKLOAD_VEC     = 36'h80000000,
  parameter logic [35:0] DRIVER_VEC       = 36'h10000000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       dse_reset_valid,
  input  logic [35:0]                dse_reset_vector,
  input  logic                       deg_out_enable,
  input  logic [LANES-1:0]           deg_valids,
  input  logic [DEG_W-1:0]           deg_out_data,
  input  logic [PERF_W-1:0]          perf_out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [MAGIC_W+DEG_W-1:0]   out_data,
  output logic [1:0]                 rec_state,
  output logic [15:0]                drop_count,
  output logic                       err_zero_valid
);

  localparam int REC_W = MAGIC_W + DEG_W;
  localparam int AW    = $clog2(FIFO_DEPTH);

  localparam logic [MAGIC_W-1:0] TAG_EMU  = MAGIC_W'(1);
  localparam logic [MAGIC_W-1:0] TAG_DEG  = MAGIC_W'(2);
  localparam logic [MAGIC_W-1:0] TAG_DONE = MAGIC_W'(3);
  localparam logic [MAGIC_W-1:0] TAG_FIN  = MAGIC_W'(4);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RECORD = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t               state, state_next;
  logic                 last_valid;
  logic [31:0]          rec_num;
  logic                 degdone_pend;

  logic                 reset_edge;
  logic                 emu_ev, fin_ev, deg_ev, done_ev;
  logic [DEG_W-1:0]     fin_payload;

  logic [REC_W-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 full, pop, push, push_ok;
  logic [REC_W-1:0]     push_data;
  logic [2:0]           drop_inc;

  function automatic logic [31:0] popcount(input logic [LANES-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) n = n + 32'(v[i]);
    return n;
  endfunction

  assign reset_edge = dse_reset_valid && !last_valid;
  assign emu_ev     = reset_edge && (dse_reset_vector == WORKLOAD_VEC);
  assign fin_ev     = reset_edge && (dse_reset_vector == DRIVER_VEC);
  assign deg_ev     = (state == RECORD) && deg_out_enable;
  assign done_ev    = degdone_pend;

`ifdef DSE_FINISH_TIMESTAMP_EN
  logic [63:0] cycle_count;

  if (DEG_W < PERF_W + 64) begin : g_width_check
    $error("DEG_W must be at least PERF_W+64 when the finish timestamp is enabled");
  end

  always_ff @(posedge clock) begin
    if (reset) cycle_count <= '0;
    else       cycle_count <= cycle_count + 64'd1;
  end

  assign fin_payload = DEG_W'({cycle_count, perf_out_data});
`else
  assign fin_payload = DEG_W'(perf_out_data);
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (emu_ev) state_next = ARMED;
      ARMED:      if (!dse_reset_valid) state_next = RECORD;
      RECORD:     if (fin_ev || rec_num >= 32'(DEG_RECORD_THRES)) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      last_valid   <= 1'b0;
      degdone_pend <= 1'b0;
    end else begin
      state        <= state_next;
      last_valid   <= dse_reset_valid;
      degdone_pend <= (state == RECORD) && (state_next != RECORD);
    end
  end

  always_ff @(posedge clock) begin
    logic [32:0] sum;
    if (reset) begin
      rec_num <= '0;
    end else if (emu_ev) begin
      rec_num <= '0;
    end else if (deg_ev) begin
      sum     = {1'b0, rec_num} + {1'b0, popcount(deg_valids)};
      rec_num <= sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset)                                       err_zero_valid <= 1'b0;
    else if (deg_ev && deg_valids == '0)             err_zero_valid <= 1'b1;
  end

  // One record per cycle; every losing event counts as a drop.
  always_comb begin
    logic [2:0] n_ev;
    n_ev      = 3'(emu_ev) + 3'(deg_ev) + 3'(done_ev) + 3'(fin_ev);
    push      = (n_ev != 3'd0);
    push_data = '0;
    if (emu_ev)       push_data = {TAG_EMU, {DEG_W{1'b0}}};
    else if (deg_ev)  push_data = {TAG_DEG, deg_out_data};
    else if (done_ev) push_data = {TAG_DONE, {DEG_W{1'b0}}};
    else if (fin_ev)  push_data = {TAG_FIN, fin_payload};
    drop_inc = push ? (n_ev - 3'd1) : 3'd0;
    if (push && !push_ok) drop_inc = drop_inc + 3'd1;
  end

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push_ok   = push && (!full || pop);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign rec_state = state;

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clock) begin
    logic [16:0] dsum;
    if (reset) begin
      drop_count <= '0;
    end else begin
      dsum       = {1'b0, drop_count} + 17'(drop_inc);
      drop_count <= dsum[16] ? 16'hFFFF : dsum[15:0];
    end
  end

endmodule

// File: tb/tb_dse_stream_endpoint.sv
// tb/tb_dse_stream_endpoint.sv - scoreboard bench for dse_stream_endpoint.
module tb_dse_stream_endpoint;

  localparam logic [35:0] WORK = 36'h80000000;
  localparam logic [35:0] DRV  = 36'h10000000;

  logic         clock = 1'b0;
  logic         reset;
  logic         dse_reset_valid;
  logic [35:0]  dse_reset_vector;
  logic         deg_out_enable;
  logic [5:0]   deg_valids;
  logic [511:0] deg_out_data;
  logic [255:0] perf_out_data;
  logic         out_valid;
  logic         out_ready;
  logic [519:0] out_data;
  logic [1:0]   rec_state;
  logic [15:0]  drop_count;
  logic         err_zero_valid;

  int applied    = 0;
  int miscompares = 0;
  logic [519:0] exp_q[$];

  dse_stream_endpoint dut (
    .clock(clock), .reset(reset),
    .dse_reset_valid(dse_reset_valid), .dse_reset_vector(dse_reset_vector),
    .deg_out_enable(deg_out_enable), .deg_valids(deg_valids),
    .deg_out_data(deg_out_data), .perf_out_data(perf_out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .rec_state(rec_state), .drop_count(drop_count), .err_zero_valid(err_zero_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [519:0] act, input logic [519:0] want);
    applied++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  function automatic logic [511:0] bd(input int i);
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[32*k +: 32] = 32'(i * 16 + k) ^ 32'hA5A5_0000;
    return d;
  endfunction

  task automatic expect_rec(input logic [7:0] tag, input logic [511:0] pl);
    exp_q.push_back({tag, pl});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic [5:0] v, input logic [511:0] d);
    deg_out_enable = 1'b1;
    deg_valids     = v;
    deg_out_data   = d;
    step();
    deg_out_enable = 1'b0;
    deg_valids     = '0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    chk(name, 520'(exp_q.size()), 520'(0));
  endtask

  task automatic emulate();
    dse_reset_valid  = 1'b1;
    dse_reset_vector = WORK;
    expect_rec(8'd1, '0);
    step();
    chk("state_armed", 520'(rec_state), 520'(1));
    step();
    step();
    dse_reset_valid = 1'b0;
    step();
    chk("state_record", 520'(rec_state), 520'(2));
  endtask

  // Monitor: every accepted output record is checked against the queue head.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          applied++;
          miscompares++;
          $display("FAIL unexpected_record got %h want none", out_data);
        end else begin
          chk("record", out_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    dse_reset_valid = 1'b0;
    dse_reset_vector = '0;
    deg_out_enable = 1'b0;
    deg_valids = '0;
    deg_out_data = '0;
    perf_out_data = '0;
    out_ready = 1'b1;
    repeat (2) step();
    chk("rst_out_valid", 520'(out_valid), 520'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_state", 520'(rec_state), 520'(0));
    chk("rst_drop", 520'(drop_count), 520'(0));
    chk("rst_err", 520'(err_zero_valid), 520'(0));
    reset = 1'b0;
    step();

    // Emulate, then 34 full-lane beats crossing the 200-lane threshold.
    emulate();
    for (int i = 0; i < 34; i++) begin
      expect_rec(8'd2, bd(i));
      beat(6'h3F, bd(i));
    end
    expect_rec(8'd3, '0);
    step();
    chk("state_done_thres", 520'(rec_state), 520'(3));
    drain("drain_thres");
    chk("drop_after_thres", 520'(drop_count), 520'(0));
    chk("err_still_clear", 520'(err_zero_valid), 520'(0));

    // Backpressure: 10 beats into an 8-deep FIFO.
    emulate();
    drain("drain_emu2");
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) expect_rec(8'd2, bd(100 + i));
      beat(6'h01, bd(100 + i));
    end
    chk("drop_overflow", 520'(drop_count), 520'(2));
    chk("hold_data0", out_data, {8'd2, bd(100)});
    step();
    chk("hold_data1", out_data, {8'd2, bd(100)});
    chk("hold_valid", 520'(out_valid), 520'(1));
    out_ready = 1'b1;
    drain("drain_overflow");

    // Finish edge in RECORD coinciding with a deg beat.
    dse_reset_valid  = 1'b1;
    dse_reset_vector = DRV;
    perf_out_data    = {8{32'hC0DE_0001}};
    expect_rec(8'd2, bd(200));
    expect_rec(8'd3, '0);
    beat(6'h3F, bd(200));
    dse_reset_valid = 1'b0;
    chk("state_done_fin", 520'(rec_state), 520'(3));
    chk("drop_fin_lost", 520'(drop_count), 520'(3));
    drain("drain_fin");

    // Finish edge in DONE records perf; unknown vector does nothing.
    dse_reset_valid  = 1'b1;
    dse_reset_vector = DRV;
    perf_out_data    = {4{64'h1234_5678_9ABC_DEF0}};
    expect_rec(8'd4, {256'd0, {4{64'h1234_5678_9ABC_DEF0}}});
    step();
    dse_reset_valid = 1'b0;
    chk("state_done_keep", 520'(rec_state), 520'(3));
    step();
    dse_reset_valid  = 1'b1;
    dse_reset_vector = 36'h0_0000_1234;
    step();
    dse_reset_valid = 1'b0;
    step();
    chk("state_other_vec", 520'(rec_state), 520'(3));
    drain("drain_finish_done");
    chk("drop_unchanged", 520'(drop_count), 520'(3));

    // Zero-valid beat sets the sticky error.
    emulate();
    expect_rec(8'd2, bd(300));
    beat(6'h00, bd(300));
    chk("err_set", 520'(err_zero_valid), 520'(1));
    repeat (3) step();
    chk("err_sticky", 520'(err_zero_valid), 520'(1));
    drain("drain_err");

    // Reset with five buffered records discards them.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) beat(6'h01, bd(400 + i));
    chk("pre_reset_valid", 520'(out_valid), 520'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("post_rst_valid", 520'(out_valid), 520'(0));
    chk("post_rst_data", out_data, '0);
    chk("post_rst_state", 520'(rec_state), 520'(0));
    chk("post_rst_drop", 520'(drop_count), 520'(0));
    chk("post_rst_err", 520'(err_zero_valid), 520'(0));
    out_ready = 1'b1;
    repeat (5) step();
    chk("final_queue", 520'(exp_q.size()), 520'(0));

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/dse_stream_endpoint.md
DSE_STREAM_ENDPOINT -- requirements
Module: dse_stream_endpoint

Interface
REQ-001 SHALL have parameters: DEG_W (512) DEG record payload bits; PERF_W (256) perf payload bits; MAGIC_W (8) record tag bits; LANES (6) DEG valid lanes; FIFO_DEPTH (8) record buffer entries, power of 2, ≥2; DEG_RECORD_THRES (200) lanes to record per phase; WORKLOAD_VEC (36'h80000000); DRIVER_VEC (36'h10000000).
REQ-002 SHALL have the following ports, each with direction, width and meaning:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- dse_reset_valid  in  1  DSE reset request level.
- dse_reset_vector  in  36  reset target.
- deg_out_enable  in  1  DEG beat valid.
- deg_valids  in  LANES  per-lane valid.
- deg_out_data  in  DEG_W  DEG payload.
- perf_out_data  in  PERF_W  perf counters.
- out_valid  out  1  record available.
- out_ready  in  1  consumer accept.
- out_data  out  MAGIC_W+DEG_W  {tag, payload}.
- rec_state  out  2  FSM state.
- drop_count  out  16  lost records, saturating.
- err_zero_valid  out  1  sticky error.

Function
REQ-003 SHALL detect reset edge = dse_reset_valid && !last_valid; last_valid is a register of dse_reset_valid.
REQ-004 SHALL classify edge: vector==WORKLOAD_VEC -> emulate event (tag 1); vector==DRIVER_VEC -> finish event (tag 4); other vectors -> no event.
REQ-005 SHALL run FSM IDLE(0) / ARMED(1) / RECORD(2) / DONE(3).
- IDLE/DONE->ARMED on emulate edge.
- ARMED->RECORD on first cycle dse_reset_valid==0.
- RECORD->DONE on finish edge, or when rec_num ≥ DEG_RECORD_THRES.
- finish edge in IDLE/ARMED/DONE: no state change.
REQ-006 SHALL clear rec_num on emulate edge.
REQ-007 SHALL, in RECORD with deg_out_enable, add popcount(deg_valids) to rec_num (32-bit, saturating at all-ones).
REQ-008 SHALL generate a DEG event (tag 2) each cycle state==RECORD && deg_out_enable, payload deg_out_data, including the cycle the threshold is crossed.
REQ-009 SHALL generate a degdone event (tag 3) in the cycle after the FSM leaves RECORD, payload zero.
REQ-010 SHALL zero the payload of emulate events.
REQ-011 SHALL use finish payload = zero-extended perf_out_data, except as REQ-021 states.
REQ-012 SHALL push at most one record per cycle, priority emulate > deg > degdone > finish; each other event in that cycle increments drop_count.
REQ-013 SHALL push into a FIFO_DEPTH FIFO.
- Push when full without same-cycle pop: record dropped, drop_count +1.
- Push while full with same-cycle pop: succeeds.
REQ-014 SHALL have out_valid = FIFO non-empty, out_data = head entry, pop on out_valid && out_ready; push-to-out_valid latency is 1 cycle.
REQ-015 SHALL hold out_data stable while out_valid && !out_ready.
REQ-016 SHALL set err_zero_valid when deg_out_enable && deg_valids==0 in RECORD; it clears only on reset.
REQ-017 SHALL saturate drop_count at 16'hFFFF.

Reset
REQ-018 SHALL on reset: FSM IDLE, FIFO empty, out_valid 0, rec_num 0, drop_count 0, err_zero_valid 0, last_valid 0, pending degdone cleared.
REQ-019 SHALL have reset asserted mid-operation discard buffered records, with no degdone emitted.
REQ-020 SHALL produce out_data 0 while empty.

Configuration
REQ-021 SHALL, with DSE_FINISH_TIMESTAMP_EN defined, keep a 64-bit free-running cycle counter (0 at reset) and give finish payload = {zeros, cycle_count[63:0], perf_out_data}, requiring DEG_W ≥ PERF_W+64 (elaboration error otherwise); without it, no counter and REQ-011 payload applies.

Verification
REQ-022 SHALL cover emulate edge (vector 36'h80000000) held 3 cycles then released -> tag 1 record, state ARMED then RECORD.
REQ-023 SHALL cover RECORD with 34 beats of deg_valids=6'h3F (204 ≥ 200) -> 34 tag 2 records, then tag 3, state DONE.
REQ-024 SHALL cover out_ready=0 during 10 DEG beats with FIFO_DEPTH=8 -> 8 buffered, drop_count=2, order preserved on drain.
REQ-025 SHALL cover a finish edge in RECORD -> state DONE, tag 3 next cycle, tag 4 record dropped (drop_count +1) since deg beat wins.
REQ-026 SHALL cover deg_out_enable with deg_valids=0 in RECORD -> err_zero_valid=1, remaining 1 until reset.
REQ-027 SHALL cover reset with FIFO holding 5 records -> out_valid 0 next cycle, all counters 0.
